// File: rtl/bus_error_responder_pkg.sv
// rtl/bus_error_responder_pkg.sv - shared types and constants for the bus error responder
package bus_error_responder_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              error;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/bus_error_responder_sat_counter.sv
// rtl/bus_error_responder_sat_counter.sv - saturating event counter
module bus_error_responder_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_error_responder.sv
// rtl/bus_error_responder.sv - default slave that error-completes rejected bus requests
// and records the first faulting address for the trap logic.
module bus_error_responder
  import bus_error_responder_pkg::*;
#(
  parameter int            N        = 32,
  parameter int            LAT      = 1,
  parameter logic [N-1:0]  ERR_DATA = N'(ERR_DATA_DEFAULT),
  parameter int            CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  input  logic             i_req_error,
  output logic             o_req_ready,
  input  logic [N-1:0]     i_addr,
  input  logic             i_we,
  output logic             o_rsp_valid,
  output logic             o_rsp_error,
  output logic [N-1:0]     o_rsp_rdata,
  input  logic             i_rsp_ready,
  output logic             o_fault_valid,
  output logic [N-1:0]     o_fault_addr,
  output logic             o_fault_we,
  input  logic             i_fault_clr,
  output logic [CNT_W-1:0] o_fault_cnt
);

  localparam int            DW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DLY_LOAD = DW'(LAT - 1);

  state_t        state;
  logic [DW-1:0] delay;
  logic          we_q;
  logic          accept;

  assign accept = i_req_valid && i_req_error && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      delay       <= '0;
      we_q        <= 1'b0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_error <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q        <= i_we;
            delay       <= DLY_LOAD;
            o_req_ready <= 1'b0;
            // With a single-cycle latency the wait state is skipped entirely.
            if (LAT == 1) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_error <= 1'b1;
              o_rsp_rdata <= i_we ? '0 : ERR_DATA;
            end else begin
              state <= WAIT;
            end
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          // Entering RESP on the edge where the count would reach zero keeps
          // the response exactly LAT edges after the accept.
          if (delay <= DW'(1)) begin
            delay       <= '0;
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_error <= 1'b1;
            o_rsp_rdata <= we_q ? '0 : ERR_DATA;
          end else begin
            delay <= delay - DW'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_error <= 1'b0;
            o_rsp_rdata <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A clear in the same cycle as an accept lets the new fault be captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fault_valid <= 1'b0;
      o_fault_addr  <= '0;
      o_fault_we    <= 1'b0;
    end else if (accept && (!o_fault_valid || i_fault_clr)) begin
      o_fault_valid <= 1'b1;
      o_fault_addr  <= i_addr;
      o_fault_we    <= i_we;
    end else if (i_fault_clr) begin
      o_fault_valid <= 1'b0;
    end
  end

  bus_error_responder_sat_counter #(
    .CNT_W(CNT_W)
  ) u_fault_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .inc  (accept),
    .count(o_fault_cnt)
  );

endmodule

// File: tb/tb_bus_error_responder.sv
// tb/tb_bus_error_responder.sv - directed self-checking bench for bus_error_responder
module tb_bus_error_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: LAT=1, CNT_W=8
  logic        a_rst, a_req_valid, a_req_error, a_req_ready, a_we;
  logic [31:0] a_addr, a_rsp_rdata, a_fault_addr;
  logic        a_rsp_valid, a_rsp_error, a_rsp_ready;
  logic        a_fault_valid, a_fault_we, a_fault_clr;
  logic [7:0]  a_fault_cnt;

  // Instance B: LAT=4, CNT_W=2
  logic        b_rst, b_req_valid, b_req_error, b_req_ready, b_we;
  logic [31:0] b_addr, b_rsp_rdata, b_fault_addr;
  logic        b_rsp_valid, b_rsp_error, b_rsp_ready;
  logic        b_fault_valid, b_fault_we, b_fault_clr;
  logic [1:0]  b_fault_cnt;

  bus_error_responder #(.N(32), .LAT(1), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst(a_rst),
    .i_req_valid(a_req_valid), .i_req_error(a_req_error), .o_req_ready(a_req_ready),
    .i_addr(a_addr), .i_we(a_we),
    .o_rsp_valid(a_rsp_valid), .o_rsp_error(a_rsp_error), .o_rsp_rdata(a_rsp_rdata),
    .i_rsp_ready(a_rsp_ready),
    .o_fault_valid(a_fault_valid), .o_fault_addr(a_fault_addr), .o_fault_we(a_fault_we),
    .i_fault_clr(a_fault_clr), .o_fault_cnt(a_fault_cnt)
  );

  bus_error_responder #(.N(32), .LAT(4), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .i_req_valid(b_req_valid), .i_req_error(b_req_error), .o_req_ready(b_req_ready),
    .i_addr(b_addr), .i_we(b_we),
    .o_rsp_valid(b_rsp_valid), .o_rsp_error(b_rsp_error), .o_rsp_rdata(b_rsp_rdata),
    .i_rsp_ready(b_rsp_ready),
    .o_fault_valid(b_fault_valid), .o_fault_addr(b_fault_addr), .o_fault_we(b_fault_we),
    .i_fault_clr(b_fault_clr), .o_fault_cnt(b_fault_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LAT=1 fault: accept, observe response next sample, then handshake.
  task automatic a_fault(input logic [31:0] addr, input logic we);
    a_req_valid = 1'b1; a_req_error = 1'b1; a_addr = addr; a_we = we;
    tick();
    a_req_valid = 1'b0; a_req_error = 1'b0;
    check("a_fault_rsp_valid", a_rsp_valid, 1);
    check("a_fault_rdata", a_rsp_rdata, we ? 64'h0 : 64'hDEAD_BEEF);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    check("a_fault_done", a_rsp_valid, 0);
  endtask

  // LAT=4 fault with bounded wait for the response.
  task automatic b_fault(input logic [31:0] addr, input logic we);
    bit seen = 0;
    b_req_valid = 1'b1; b_req_error = 1'b1; b_addr = addr; b_we = we;
    tick();
    b_req_valid = 1'b0; b_req_error = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = b_rsp_valid;
    end
    check("b_fault_rsp_seen", seen, 1);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    a_rst = 1; a_req_valid = 0; a_req_error = 0; a_addr = '0; a_we = 0; a_rsp_ready = 0; a_fault_clr = 0;
    b_rst = 1; b_req_valid = 0; b_req_error = 0; b_addr = '0; b_we = 0; b_rsp_ready = 0; b_fault_clr = 0;
    tick(); tick();
    check("rst_req_ready", a_req_ready, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_error", a_rsp_error, 0);
    check("rst_rdata", a_rsp_rdata, 0);
    check("rst_fault_valid", a_fault_valid, 0);
    check("rst_fault_addr", a_fault_addr, 0);
    check("rst_fault_cnt", a_fault_cnt, 0);
    a_rst = 0; b_rst = 0;
    tick();
    check("idle_req_ready", a_req_ready, 1);

    // LAT=1 read error with response held for one extra cycle
    a_req_valid = 1; a_req_error = 1; a_addr = 32'h4000_0010; a_we = 0;
    tick();
    a_req_valid = 0; a_req_error = 0;
    check("rd_rsp_valid", a_rsp_valid, 1);
    check("rd_rsp_error", a_rsp_error, 1);
    check("rd_rdata", a_rsp_rdata, 64'hDEAD_BEEF);
    check("rd_req_ready", a_req_ready, 0);
    check("rd_fault_valid", a_fault_valid, 1);
    check("rd_fault_addr", a_fault_addr, 64'h4000_0010);
    check("rd_fault_we", a_fault_we, 0);
    check("rd_fault_cnt", a_fault_cnt, 1);
    tick();
    check("rd_hold_valid", a_rsp_valid, 1);
    check("rd_hold_rdata", a_rsp_rdata, 64'hDEAD_BEEF);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    check("rd_done_valid", a_rsp_valid, 0);
    check("rd_done_ready", a_req_ready, 1);

    // back-to-back faults keep the first capture; clear releases it
    a_fault(32'h100, 0);
    a_fault(32'h200, 0);
    check("b2b_fault_addr", a_fault_addr, 64'h4000_0010);
    check("b2b_fault_cnt", a_fault_cnt, 3);
    a_fault_clr = 1;
    tick();
    a_fault_clr = 0;
    check("clr_fault_valid", a_fault_valid, 0);
    check("clr_addr_held", a_fault_addr, 64'h4000_0010);
    check("clr_cnt_held", a_fault_cnt, 3);
    a_fault(32'h300, 1);
    check("recap_fault_addr", a_fault_addr, 64'h300);
    check("recap_fault_we", a_fault_we, 1);
    check("recap_fault_cnt", a_fault_cnt, 4);

    // clear and accept in the same cycle: capture wins
    a_fault_clr = 1; a_req_valid = 1; a_req_error = 1; a_addr = 32'h500; a_we = 0;
    tick();
    a_fault_clr = 0; a_req_valid = 0; a_req_error = 0;
    check("same_fault_valid", a_fault_valid, 1);
    check("same_fault_addr", a_fault_addr, 64'h500);
    check("same_fault_cnt", a_fault_cnt, 5);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;

    // non-error requests are ignored
    a_req_valid = 1; a_req_error = 0; a_addr = 32'h600;
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (a_rsp_valid !== 1'b0) bad++;
      end
      check("ignore_no_rsp", bad, 0);
    end
    a_req_valid = 0;
    check("ignore_cnt", a_fault_cnt, 5);
    check("ignore_ready", a_req_ready, 1);

    // accept while rsp_ready already high: same latency, immediate handshake
    a_rsp_ready = 1; a_req_valid = 1; a_req_error = 1; a_addr = 32'h700; a_we = 0;
    tick();
    a_req_valid = 0; a_req_error = 0;
    check("rr_rsp_valid", a_rsp_valid, 1);
    tick();
    a_rsp_ready = 0;
    check("rr_done", a_rsp_valid, 0);
    check("rr_cnt", a_fault_cnt, 6);

    // LAT=4 write with response stalled
    check("b_idle_ready", b_req_ready, 1);
    b_req_valid = 1; b_req_error = 1; b_addr = 32'h8000_0004; b_we = 1;
    tick();
    b_req_valid = 0; b_req_error = 0;
    check("b_k0_valid", b_rsp_valid, 0);
    check("b_k0_ready", b_req_ready, 0);
    tick();
    check("b_k1_valid", b_rsp_valid, 0);
    tick();
    check("b_k2_valid", b_rsp_valid, 0);
    check("b_k2_ready", b_req_ready, 0);
    tick();
    check("b_k3_valid", b_rsp_valid, 1);
    check("b_k3_error", b_rsp_error, 1);
    check("b_k3_rdata", b_rsp_rdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("b_hold_valid", b_rsp_valid, 1);
      check("b_hold_rdata", b_rsp_rdata, 0);
      check("b_hold_ready", b_req_ready, 0);
    end
    check("b_fault_we", b_fault_we, 1);
    check("b_cnt1", b_fault_cnt, 1);
    b_rsp_ready = 1;
    tick();
    b_rsp_ready = 0;
    check("b_done_valid", b_rsp_valid, 0);
    check("b_done_ready", b_req_ready, 1);

    // saturation at 2^2-1 after five faults
    b_fault(32'h10, 0);
    check("b_cnt2", b_fault_cnt, 2);
    b_fault(32'h20, 0);
    check("b_cnt3", b_fault_cnt, 3);
    b_fault(32'h30, 0);
    b_fault(32'h40, 0);
    check("b_cnt_sat", b_fault_cnt, 3);
    check("b_fault_addr_first", b_fault_addr, 64'h8000_0004);

    // reset during WAIT drops the pending response
    b_req_valid = 1; b_req_error = 1; b_addr = 32'h50; b_we = 0;
    tick();
    b_req_valid = 0; b_req_error = 0;
    tick();
    b_rst = 1;
    tick();
    b_rst = 0;
    check("b_rst_valid", b_rsp_valid, 0);
    check("b_rst_error", b_rsp_error, 0);
    check("b_rst_rdata", b_rsp_rdata, 0);
    check("b_rst_ready", b_req_ready, 0);
    check("b_rst_fvalid", b_fault_valid, 0);
    check("b_rst_faddr", b_fault_addr, 0);
    check("b_rst_fwe", b_fault_we, 0);
    check("b_rst_cnt", b_fault_cnt, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (b_rsp_valid !== 1'b0) bad++;
      end
      check("b_rst_dropped", bad, 0);
    end
    check("b_rst_idle_ready", b_req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_error_responder.md
Name: bus_error_responder

Overview:
Default responder on the core data/instruction bus. It completes any transaction whose address the address validation unit rejects, so the initiator never hangs. It returns an error response after a programmable delay. It also captures the first faulting address and direction in sticky registers for the trap logic, and keeps a saturating count of all faults.

Parameters:
N, 32, address/data width
LAT, 1, cycles from request acceptance to o_rsp_valid (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on an error response (width N)
CNT_W, 8, width of saturating fault counter

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_req_valid  input  1  initiator request valid
i_req_error  input  1  address validation error for the current request
o_req_ready  output  1  responder accepts request (only meaningful when i_req_error)
i_addr  input  N  request address
i_we  input  1  request is a write
o_rsp_valid  output  1  response valid
o_rsp_error  output  1  response carries an error
o_rsp_rdata  output  N  response read data
i_rsp_ready  input  1  initiator accepts response
o_fault_valid  output  1  sticky: a fault has been captured
o_fault_addr  output  N  captured faulting address
o_fault_we  output  1  captured fault was a write
i_fault_clr  input  1  clear the sticky capture
o_fault_cnt  output  CNT_W  saturating fault count

Behaviour:
- Single clock i_clk. Reset is synchronous and active-high on i_rst. All state is sampled on the rising edge.
- Reset values: state IDLE; o_req_ready 0; o_rsp_valid 0; o_rsp_error 0; o_rsp_rdata 0; o_fault_valid 0; o_fault_addr 0; o_fault_we 0; o_fault_cnt 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready = 1 (registered). Accept occurs when i_req_valid && i_req_error && o_req_ready.
  - On accept: latch i_addr and i_we, load delay counter with LAT-1, and move to WAIT. If LAT==1, move directly to RESP.
  - Requests with i_req_error==0 are ignored; they belong to a real slave.
- WAIT:
  - o_req_ready = 0.
  - Counter decrements each cycle; at 0 the FSM moves to RESP.
- RESP:
  - o_rsp_valid = 1, o_rsp_error = 1.
  - o_rsp_rdata = ERR_DATA for reads, 0 for writes.
  - Outputs hold stable until i_rsp_ready. On the handshake, return to IDLE with o_rsp_valid=0 the following cycle.
- Latency: accept at edge k gives o_rsp_valid high from edge k+LAT.
- Throughput: one outstanding transaction. The next accept is possible the cycle after the response handshake.
- Fault capture (on each accept):
  - If o_fault_valid==0, load o_fault_addr/o_fault_we and set o_fault_valid.
  - Later faults do not overwrite the capture.
  - o_fault_cnt increments and saturates at 2^CNT_W-1.
- i_fault_clr clears o_fault_valid only; addr/we hold their last values and the counter is not cleared.
- If i_fault_clr and an accept occur in the same cycle, the new fault is captured and o_fault_valid stays 1: capture wins over clear.
- If i_rst is asserted mid-transaction (WAIT or RESP), the FSM returns to IDLE and the pending response is dropped. Reset wins over every other input.
- An accept with i_req_valid and i_req_error both 1 in IDLE while i_rsp_ready is already high has no effect on timing.

Decomposition:
- Shared bus package: state enum (IDLE/WAIT/RESP), the response struct {valid, error, rdata}, and the ERR_DATA default constant.
- No sub-module is needed beyond an optional sat_counter (CNT_W), which is reusable by perf counters.

Test Plan:
- Read error, LAT=1: addr=0x4000_0010, we=0, accept at cycle 5 -> o_rsp_valid at cycle 6, rdata=0xDEADBEEF, error=1; fault_addr=0x4000_0010, fault_valid=1, cnt=1.
- LAT=4 write with i_rsp_ready held low 3 cycles -> rsp_valid asserted 4 cycles after accept, held stable 3 cycles, rdata=0; o_req_ready=0 throughout.
- Two back-to-back faults, 0x100 then 0x200 -> fault_addr stays 0x100, cnt=2. Then i_fault_clr, then a third fault 0x300 -> fault_addr=0x300.
- Same-cycle i_fault_clr and accept of 0x500 -> fault_valid=1, fault_addr=0x500.
- i_req_valid=1, i_req_error=0 for 10 cycles -> no response, cnt unchanged.
- CNT_W=2, 5 faults -> cnt saturates at 3. Reset asserted during WAIT -> next cycle IDLE, rsp_valid=0, all outputs at reset values.
